// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
// Latency: the product is valid WIDTH+1 cycles after operand acceptance. Minimum issue interval is WIDTH+3 cycles.
// Backpressure: DONE holds the product until out_ready. in_ready is high only in IDLE.
module booth_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  // One guard bit lets signed and unsigned operands share the same signed datapath.
  localparam int XW = WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  logic [XW-1:0]        r_m;
  logic [XW-1:0]        r_hq;
  logic [XW-1:0]        r_lq;
  logic                 r_q1;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [2*WIDTH-1:0]   r_product;

  logic [XW-1:0]        w_a_ext;
  logic [XW-1:0]        w_b_ext;
  logic [XW-1:0]        w_sum;
  logic [XW-1:0]        w_hq_nxt;
  logic [XW-1:0]        w_lq_nxt;
  logic [2*WIDTH-1:0]   w_prod_nxt;

  assign w_a_ext = {is_signed & a[WIDTH-1], a};
  assign w_b_ext = {is_signed & b[WIDTH-1], b};

  // Booth recode of the current multiplier bit pair selects add, subtract or pass.
  always_comb begin
    w_sum = r_hq;
    case ({r_lq[0], r_q1})
      2'b01:   w_sum = r_hq + r_m;
      2'b10:   w_sum = r_hq - r_m;
      default: w_sum = r_hq;
    endcase
  end

  // The arithmetic right shift across {HQ,LQ} replicates the MSB of the freshly added HQ.
  assign w_hq_nxt   = {w_sum[XW-1], w_sum[XW-1:1]};
  assign w_lq_nxt   = {w_sum[0], r_lq[XW-1:1]};
  assign w_prod_nxt = {w_hq_nxt[WIDTH-2:0], w_lq_nxt};

  // Control FSM and datapath registers. The handshake outputs are registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_m         <= '0;
      r_hq        <= '0;
      r_lq        <= '0;
      r_q1        <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_product   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_m        <= w_a_ext;
            r_lq       <= w_b_ext;
            r_hq       <= '0;
            r_q1       <= 1'b0;
            r_cnt      <= CNT_W'(WIDTH + 1);
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_hq  <= w_hq_nxt;
          r_lq  <= w_lq_nxt;
          r_q1  <= r_lq[0];
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_product   <= w_prod_nxt;
          end
        end
        S_DONE: begin
          // Operands presented in this cycle are not captured. IDLE takes them on the next edge.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign product   = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed-vector bench for booth_mult_seq (WIDTH=8).
// Stimulus pushes hand-computed products into a scoreboard.
// A negedge monitor pops the scoreboard and compares on each output handshake.
module tb_booth_mult_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] sb_q[$];
  string          name_q[$];
  logic [2*W-1:0] m_exp;
  string          m_nm;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each accepted product is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h, expected no output", product);
      end else begin
        m_exp = sb_q.pop_front();
        m_nm  = name_q.pop_front();
        chk(m_nm, {16'h0, product}, {16'h0, m_exp});
      end
    end
  end

  task automatic push_exp(input logic [2*W-1:0] exp, input string nm);
    sb_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Issue one operation with out_ready high, then check the latency and the drain.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic ts, input logic [2*W-1:0] exp, input string nm);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin tick(); n++; end
    chk({nm, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    a = ta; b = tb_v; is_signed = ts; in_valid = 1'b1;
    push_exp(exp, nm);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin tick(); n++; end
    chk({nm, "_latency"}, n, W + 1);
    n = 0;
    while (out_valid === 1'b1 && n < 50) begin tick(); n++; end
    chk({nm, "_drained"}, {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",  {31'h0, in_ready},  32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_busy",      {31'h0, busy},      32'h0);
    chk("rst_product",   {16'h0, product},   32'h0);
    rst = 1'b0;
    tick();

    // Signed and unsigned directed vectors.
    do_op(8'h03, 8'hFB, 1'b1, 16'hFFF1, "s_3x-5");
    do_op(8'h80, 8'h80, 1'b1, 16'h4000, "s_minxmin");
    do_op(8'h80, 8'h7F, 1'b1, 16'hC080, "s_minxmax");
    do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_maxxmax");
    do_op(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1xm1");
    do_op(8'h00, 8'hA5, 1'b1, 16'h0000, "s_zero");
    do_op(8'h01, 8'hA5, 1'b1, 16'hFFA5, "s_ident");
    do_op(8'h01, 8'hA5, 1'b0, 16'h00A5, "u_ident");

    // Backpressure: hold DONE while new operands are offered.
    out_ready = 1'b0;
    a = 8'h80; b = 8'h7F; is_signed = 1'b1; in_valid = 1'b1;
    push_exp(16'hC080, "bp_result");
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin tick(); n++; end
    chk("bp_latency", n, W + 1);
    a = 8'h11; b = 8'h22; is_signed = 1'b0; in_valid = 1'b1;
    push_exp(16'h0242, "bp_next");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_product", {16'h0, product}, 32'hC080);
      chk("bp_hold_valid",   {31'h0, out_valid}, 32'h1);
      chk("bp_hold_in_rdy",  {31'h0, in_ready},  32'h0);
      chk("bp_hold_busy",    {31'h0, busy},      32'h1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_in_ready",  {31'h0, in_ready},  32'h1);
    chk("bp_rel_out_valid", {31'h0, out_valid}, 32'h0);
    chk("bp_rel_busy",      {31'h0, busy},      32'h0);
    chk("bp_rel_product",   {16'h0, product},   32'hC080);
    tick();
    chk("bp_accept_busy",   {31'h0, busy},      32'h1);
    chk("bp_accept_in_rdy", {31'h0, in_ready},  32'h0);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin tick(); n++; end
    chk("bp_next_latency", n, W + 1);
    n = 0;
    while (out_valid === 1'b1 && n < 50) begin tick(); n++; end
    chk("bp_next_drained", {31'h0, out_valid}, 32'h0);

    // Reset during the 4th RUN cycle discards the partial result.
    a = 8'h55; b = 8'h33; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready",  {31'h0, in_ready},  32'h1);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_busy",      {31'h0, busy},      32'h0);
    chk("midrst_product",   {16'h0, product},   32'h0);
    do_op(8'h07, 8'h06, 1'b0, 16'h002A, "u_7x6_after_rst");

    tick();
    tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
